alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer that performs 16-bit unsigned multiply and unsigned divide using the existing combinational 16-bit ALU.
- Issues exactly one ALU operation per cycle and keeps the shift/compare bookkeeping in local registers.
- Sits beside the datapath ALU, drives its operand and control inputs, and presents a start/done handshake to the control unit.

---
 rtl/alu_muldiv_seq.sv | 136 +++++++++++++
 tb/tb_alu_muldiv_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// Sequential unsigned multiply/divide that borrows the datapath ALU one op per cycle.
// Shift-add multiply and restoring divide; start/done handshake toward control.
module alu_muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] p, m, q, r, d;
    logic [CW-1:0]    count;
    logic             accept;
    logic [WIDTH:0]   rp;
    logic             ge;

    assign accept = start && (state == S_IDLE || state == S_FINISH);
    assign busy   = (state == S_MUL) || (state == S_DIV);
    assign done   = (state == S_FINISH);

    // Shifted partial remainder is 17 bits wide; the compare must see the carry-out bit.
    assign rp = {r, q[WIDTH-1]};
    assign ge = (rp >= {1'b0, d});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        alu_in1     = '0;
        alu_in2     = '0;
        alu_control = 3'd0;
        case (state)
            S_IDLE, S_FINISH: begin
                if (accept) begin
                    case (op)
                        2'd0:    state_n = S_MUL;
                        2'd1:    state_n = (b != '0) ? S_DIV : S_FINISH;
                        default: state_n = S_FINISH;
                    endcase
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_MUL: begin
                alu_in1     = p;
                alu_in2     = m;
                alu_control = 3'd2;
                if (count == '0) state_n = S_FINISH;
            end
            S_DIV: begin
                alu_in1     = rp[WIDTH-1:0];
                alu_in2     = d;
                alu_control = 3'd3;
                if (count == '0) state_n = S_FINISH;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p         <= '0;
            m         <= '0;
            q         <= '0;
            r         <= '0;
            d         <= '0;
            count     <= '0;
            err       <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
        end else if (accept) begin
            err <= 1'b0;
            case (op)
                2'd0: begin
                    p     <= '0;
                    m     <= a;
                    q     <= b;
                    count <= CW'(WIDTH-1);
                end
                2'd1: begin
                    if (b != '0) begin
                        r     <= '0;
                        q     <= a;
                        d     <= b;
                        count <= CW'(WIDTH-1);
                    end else begin
                        err       <= 1'b1;
                        result_lo <= '1;
                        result_hi <= a;
                    end
                end
                default: begin
                    err       <= 1'b1;
                    result_lo <= '0;
                    result_hi <= '0;
                end
            endcase
        end else if (state == S_MUL) begin
            if (q[0]) p <= alu_result;
            m     <= m << 1;
            q     <= q >> 1;
            count <= count - CW'(1);
            if (count == '0) begin
                result_lo <= q[0] ? alu_result : p;
                result_hi <= '0;
            end
        end else if (state == S_DIV) begin
            r     <= ge ? alu_result : rp[WIDTH-1:0];
            q     <= {q[WIDTH-2:0], ge};
            count <= count - CW'(1);
            if (count == '0) begin
                result_lo <= {q[WIDTH-2:0], ge};
                result_hi <= ge ? alu_result : rp[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed plus random bench for alu_muldiv_seq; models the ALU and checks results
// against plain-arithmetic expectations.
module tb_alu_muldiv_seq;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        busy, done, err;
    logic [15:0] result_lo, result_hi, alu_in1, alu_in2, alu_result;
    logic [2:0]  alu_control;

    int n_checks = 0;
    int n_fail   = 0;

    alu_muldiv_seq #(.WIDTH(16)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .err(err), .result_lo(result_lo), .result_hi(result_hi),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
        .alu_result(alu_result)
    );

    // Datapath ALU stand-in: 2=add, 3=sub, anything else 0.
    always_comb begin
        case (alu_control)
            3'd2:    alu_result = alu_in1 + alu_in2;
            3'd3:    alu_result = alu_in1 - alu_in2;
            default: alu_result = 16'h0;
        endcase
    end

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference results straight from unsigned arithmetic.
    task automatic model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] lo, output logic [15:0] hi, output logic e,
                         output logic normal);
        logic [31:0] prod;
        prod = 32'(x) * 32'(y);
        lo = 16'h0; hi = 16'h0; e = 1'b0; normal = 1'b0;
        if (o == 2'd0) begin
            lo = prod[15:0]; normal = 1'b1;
        end else if (o == 2'd1 && y != 16'h0) begin
            lo = x / y; hi = x % y; normal = 1'b1;
        end else if (o == 2'd1) begin
            lo = 16'hFFFF; hi = x; e = 1'b1;
        end else begin
            e = 1'b1;
        end
    endtask

    // Waits from the first negedge after the accepting edge up to done, checking
    // busy/alu_control every cycle and latency, then results.
    task automatic finish_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                             input logic [15:0] y);
        logic [15:0] lo, hi;
        logic e, normal;
        int cyc;
        model(o, x, y, lo, hi, e, normal);
        cyc = 1;
        while (!done && cyc < 40) begin
            check({tag, ".busy"}, 32'(busy), 32'(normal));
            check({tag, ".aluctl"}, 32'(alu_control), (o == 2'd0) ? 32'd2 : 32'd3);
            @(negedge clock);
            cyc++;
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".latency"}, 32'(cyc), normal ? 32'd17 : 32'd1);
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check({tag, ".lo"}, 32'(result_lo), 32'(lo));
        check({tag, ".hi"}, 32'(result_hi), 32'(hi));
        check({tag, ".err"}, 32'(err), 32'(e));
    endtask

    task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                          input logic [15:0] y);
        issue(o, x, y);
        finish_op(tag, o, x, y);
        @(negedge clock);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".idle_alu"}, {alu_control, alu_in1[7:0]}, 32'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [15:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 2'd0; a = 16'h0; b = 16'h0;
        repeat (2) @(negedge clock);
        check("reset.outs", {13'h0, busy, done, err, result_lo | result_hi}, 32'd0);
        check("reset.alu", {alu_control, alu_in1, alu_in2[12:0]}, 32'd0);
        reset = 1'b0;

        run_op("mul3x5",      2'd0, 16'h0003, 16'h0005);
        run_op("mulwrap1",    2'd0, 16'h1234, 16'h0100);
        run_op("mulffff",     2'd0, 16'hFFFF, 16'hFFFF);
        run_op("mulzero",     2'd0, 16'h0000, 16'hFFFF);
        run_op("div100_7",    2'd1, 16'h0064, 16'h0007);
        run_op("divffff_1",   2'd1, 16'hFFFF, 16'h0001);
        run_op("divffff_8k",  2'd1, 16'hFFFF, 16'h8000);
        run_op("div5_9",      2'd1, 16'h0005, 16'h0009);
        run_op("divzero",     2'd1, 16'h1234, 16'h0000);
        run_op("illegal3",    2'd3, 16'h5555, 16'hAAAA);
        run_op("errclear",    2'd0, 16'h0003, 16'h0005);

        // Start during busy is ignored.
        issue(2'd0, 16'h0011, 16'h0003);
        repeat (3) @(negedge clock);
        start = 1'b1; op = 2'd1; a = 16'h9999; b = 16'h0002;
        @(negedge clock);
        start = 1'b0;
        while (!done && busy) @(negedge clock);
        check("ignore.lo", 32'(result_lo), 32'h0033);
        check("ignore.err", 32'(err), 32'd0);

        // Start held through the done cycle is accepted back-to-back.
        issue(2'd1, 16'h0064, 16'h0007);
        for (int i = 0; i < 40 && !done; i++) @(negedge clock);
        check("b2b.first_done", 32'(done), 32'd1);
        start = 1'b1; op = 2'd0; a = 16'h0002; b = 16'h0003;
        @(negedge clock);
        start = 1'b0;
        finish_op("b2b.mul2x3", 2'd0, 16'h0002, 16'h0003);

        // Async reset mid-divide clears everything without a clock edge.
        issue(2'd1, 16'hABCD, 16'h0013);
        repeat (7) @(negedge clock);
        #2 reset = 1'b1;
        #1 check("rst_mid.outs", {13'h0, busy, done, err, result_lo | result_hi}, 32'd0);
        check("rst_mid.alu", 32'(alu_control), 32'd0);
        repeat (3) begin
            @(negedge clock);
            check("rst_mid.no_done", 32'(done), 32'd0);
        end
        reset = 1'b0;
        run_op("mul7x9", 2'd0, 16'h0007, 16'h0009);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 9) < 4 ? 0 : ($urandom_range(0, 9) < 8 ? 1 : 3));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom >> $urandom_range(0, 16));
            run_op($sformatf("rnd%0d", i), ro, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
